pwm_capture: RTL

//  Servo PWM receiver: measures high time and rise-to-rise period of an external
//  PWM line, in clk cycles (100 MHz; 100000 cycles = 1 ms).

---
 rtl/pwm_capture.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Servo PWM receiver: measures high time and rise-to-rise period of pwm_in in clk cycles.
// Latency: an input edge reaches the FSM SYNC_STAGES+1 cycles later (+DEGLITCH with the
//          filter), and results appear one cycle after that.
// Backpressure: none. valid and timeout are one-cycle strobes and are never stalled.
//
// Ports:
//   clk        system clock (100 MHz nominal)
//   res        synchronous reset, active-high
//   pwm_in     asynchronous PWM input
//   d_out      last measured high time, cycles
//   t_out      last measured period (rise to rise), cycles
//   valid      1-cycle strobe: d_out/t_out/range_err updated
//   range_err  d_out outside [MIN_HIGH, MAX_HIGH]; updated with valid
//   timeout    1-cycle strobe: TIMEOUT cycles elapsed without a completed period
//   lock       high after a valid, low after reset or timeout
//
// Build option: define PWM_DEGLITCH_EN to insert a level filter after the synchronizer
// that rejects pulses and gaps shorter than DEGLITCH cycles.
// SYNC_STAGES must be >= 2. TIMEOUT must be < 2^32-1.

module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4000000,
    parameter int MIN_HIGH    = 50000,
    parameter int MAX_HIGH    = 250000,
    parameter int DEGLITCH    = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        pwm_in,
    output logic [31:0] d_out,
    output logic [31:0] t_out,
    output logic        valid,
    output logic        range_err,
    output logic        timeout,
    output logic        lock
);

    localparam logic [31:0] TMO  = 32'(TIMEOUT);
    localparam logic [31:0] MINH = 32'(MIN_HIGH);
    localparam logic [31:0] MAXH = 32'(MAX_HIGH);

    // After reset the synchronizer (and filter) still hold 0 regardless of the pin.
    // SEEK must not trust s until that pipeline has been refilled from the real
    // input, otherwise a pin that is high through reset would look like a fresh
    // low-to-high edge and its partial pulse would be measured.
    localparam int SETTLE = SYNC_STAGES + DEGLITCH + 1;
    localparam int STW    = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        SEEK,
        ARMED,
        HIGH,
        LOW
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;

    always_ff @(posedge clk) begin
        if (res) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Optional level filter
    // ------------------------------------------------------------------
    logic s;

`ifdef PWM_DEGLITCH_EN
    localparam int GW = $clog2(DEGLITCH + 1);

    logic [GW-1:0] glt_cnt_q;
    logic          filt_q;

    // The filtered level flips only once the synchronized input has disagreed
    // with it for DEGLITCH consecutive cycles. Both edge directions see the same
    // delay, so measured high time and period are preserved for clean input.
    always_ff @(posedge clk) begin
        if (res) begin
            glt_cnt_q <= '0;
            filt_q    <= 1'b0;
        end else if (s_sync == filt_q) begin
            glt_cnt_q <= '0;
        end else if (glt_cnt_q == GW'(DEGLITCH - 1)) begin
            glt_cnt_q <= '0;
            filt_q    <= s_sync;
        end else begin
            glt_cnt_q <= glt_cnt_q + GW'(1);
        end
    end

    assign s = filt_q;
`else
    assign s = s_sync;
`endif

    // ------------------------------------------------------------------
    // Edge detection and post-reset settling
    // ------------------------------------------------------------------
    logic           s_q;
    logic           rise;
    logic           fall;
    logic [STW-1:0] settle_q;
    logic           settled;

    always_ff @(posedge clk) begin
        if (res) begin
            s_q      <= 1'b0;
            settle_q <= '0;
        end else begin
            s_q <= s;
            if (settle_q != STW'(SETTLE)) begin
                settle_q <= settle_q + STW'(1);
            end
        end
    end

    assign rise    = s & ~s_q;
    assign fall    = ~s & s_q;
    assign settled = (settle_q == STW'(SETTLE));

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [31:0] cnt_h_q;
    logic [31:0] cnt_t_q;
    logic [31:0] d_q;
    logic [31:0] t_q;
    logic        valid_q;
    logic        range_err_q;
    logic        timeout_q;
    logic        lock_q;

    logic [31:0] cnt_h_inc;
    logic [31:0] cnt_t_inc;
    logic        tmo_hit;
    logic        range_err_d;

    // Counters saturate at TIMEOUT so they can never wrap while waiting.
    assign cnt_h_inc = (cnt_h_q >= TMO) ? TMO : cnt_h_q + 32'd1;
    assign cnt_t_inc = (cnt_t_q >= TMO) ? TMO : cnt_t_q + 32'd1;

    // A rise arriving on the very cycle the limit is reached still completes
    // the period; only a rise-less cycle at the limit is a loss of signal.
    assign tmo_hit     = (cnt_t_q >= TMO) & ~rise;
    assign range_err_d = (cnt_h_q < MINH) | (cnt_h_q > MAXH);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= SEEK;
            cnt_h_q     <= '0;
            cnt_t_q     <= '0;
            d_q         <= '0;
            t_q         <= '0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;

            case (state_q)
                // Wait for a low level so a pulse already in progress is skipped.
                SEEK: begin
                    if (settled && !s) begin
                        state_q <= ARMED;
                        cnt_h_q <= '0;
                        cnt_t_q <= '0;
                    end
                end

                // First rise starts a measurement; no result is produced yet.
                ARMED: begin
                    if (rise) begin
                        state_q <= HIGH;
                        cnt_h_q <= 32'd1;
                        cnt_t_q <= 32'd1;
                    end else if (tmo_hit) begin
                        state_q   <= SEEK;
                        timeout_q <= 1'b1;
                        lock_q    <= 1'b0;
                    end else begin
                        cnt_t_q <= cnt_t_inc;
                    end
                end

                HIGH: begin
                    if (tmo_hit) begin
                        state_q   <= SEEK;
                        timeout_q <= 1'b1;
                        lock_q    <= 1'b0;
                    end else if (s) begin
                        cnt_h_q <= cnt_h_inc;
                        cnt_t_q <= cnt_t_inc;
                    end else if (fall) begin
                        state_q <= LOW;
                        cnt_t_q <= cnt_t_inc;
                    end
                end

                // The next rise closes the period and immediately opens the next one.
                LOW: begin
                    if (rise) begin
                        state_q     <= HIGH;
                        d_q         <= cnt_h_q;
                        t_q         <= cnt_t_q;
                        range_err_q <= range_err_d;
                        valid_q     <= 1'b1;
                        lock_q      <= 1'b1;
                        cnt_h_q     <= 32'd1;
                        cnt_t_q     <= 32'd1;
                    end else if (tmo_hit) begin
                        state_q   <= SEEK;
                        timeout_q <= 1'b1;
                        lock_q    <= 1'b0;
                    end else begin
                        cnt_t_q <= cnt_t_inc;
                    end
                end

                default: begin
                    state_q <= SEEK;
                end
            endcase
        end
    end

    assign d_out     = d_q;
    assign t_out     = t_q;
    assign valid     = valid_q;
    assign range_err = range_err_q;
    assign timeout   = timeout_q;
    assign lock      = lock_q;

endmodule
